mult_share_arbiter: RTL and testbench

Shares one 8x8 combinational array multiplier among `N_REQ` requesters. Per-requester valid/ready request ports are arbitrated round-robin. Winning operands are registered into the datapath and the 16-bit product is captured. The result returns on a single valid/ready response port tagged with the requester index. The block sits between the multiplier datapath and the client blocks that need products.

---
 rtl/mult_pkg.sv | 13 +
 rtl/multiplier_array.sv | 18 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/mult_share_arbiter.sv | 89 ++++++++
 tb/tb_mult_share_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and widths for the shared-multiplier arbiter slice.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RSP  = 2'd2
  } state_t;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

endpackage

// File: rtl/multiplier_array.sv
// Unsigned 8x8 array multiplier, full 16-bit product.
// Purely combinational; no backpressure.
module multiplier_array
  import mult_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] p
);

  always_comb begin
    p = '0;
    for (int i = 0; i < OP_W; i++) begin
      if (b[i]) p = p + (PROD_W'(a) << i);
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first set request at or above ptr, wrapping modulo N.
// Purely combinational; no backpressure of its own.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW  = $clog2(N);
  localparam int IW1 = IW + 1;

  logic [IW:0] idx;
  logic        found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      // one extra bit so ptr+k cannot overflow before the modulo-N fold
      idx = {1'b0, ptr} + IW1'(k);
      if (idx >= IW1'(N)) idx = idx - IW1'(N);
      if (!found && req[idx[IW-1:0]]) begin
        found              = 1'b1;
        gnt[idx[IW-1:0]]   = 1'b1;
        gnt_idx            = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one multiplier among N_REQ requesters, round-robin, id-tagged response.
// Response 2 edges after accept; rsp_ready low stalls in RSP and blocks new accepts.
module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*OP_W-1:0]    req_a,
  input  logic [N_REQ*OP_W-1:0]    req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [PROD_W-1:0]        rsp_product,
  output logic                     busy
);

  localparam int ID_W = $clog2(N_REQ);

  state_t              state;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     gnt_idx;
  logic [N_REQ-1:0]    gnt;
  logic [OP_W-1:0]     op_a;
  logic [OP_W-1:0]     op_b;
  logic [PROD_W-1:0]   mul_p;
  logic                any_req;

  assign any_req = |req_valid;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  multiplier_array u_mul (
    .a (op_a),
    .b (op_b),
    .p (mul_p)
  );

  // rst_n gating keeps req_ready quiet while reset is held
  assign req_ready = (rst_n && state == IDLE) ? gnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      op_a        <= '0;
      op_b        <= '0;
      rsp_id      <= '0;
      rsp_product <= '0;
      rsp_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            op_a   <= req_a[int'(gnt_idx)*OP_W +: OP_W];
            op_b   <= req_b[int'(gnt_idx)*OP_W +: OP_W];
            rsp_id <= gnt_idx;
            ptr    <= (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
            busy   <= 1'b1;
            state  <= MUL;
          end
        end
        MUL: begin
          rsp_product <= mul_p;
          rsp_valid   <= 1'b1;
          state       <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed and randomized transactions against a transaction-level model of the shared multiplier.
module tb_mult_share_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*8-1:0]  req_a;
  logic [N*8-1:0]  req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [15:0]     rsp_product;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int mptr   = 0;
  logic [7:0] ta [N];
  logic [7:0] tbv[N];

  always #5 clk = ~clk;

  mult_share_arbiter #(.N_REQ(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic load_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*8 +: 8] = ta[i];
      req_b[i*8 +: 8] = tbv[i];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    mptr = 0;
    #1;
  endtask

  // One full transaction; mask must be non-zero. Returns what the DUT presented in RSP.
  task automatic run_txn(input logic [N-1:0] mask, input int stall,
                         output logic [15:0] op, output logic [1:0] oid);
    int g;
    logic [15:0] ep;
    load_ops();
    req_valid = mask;
    rsp_ready = (stall == 0);
    #1;
    g  = rr_pick(mask, mptr);
    ep = 16'(int'(ta[g]) * int'(tbv[g]));
    chk("req_ready_accept", 32'(req_ready), 32'(1) << g);
    chk("busy_idle", 32'(busy), 0);
    chk("rsp_valid_idle", 32'(rsp_valid), 0);
    mptr = (g + 1) % N;
    tick();
    chk("req_ready_mul", 32'(req_ready), 0);
    chk("busy_mul", 32'(busy), 1);
    chk("rsp_valid_mul", 32'(rsp_valid), 0);
    tick();
    op  = rsp_product;
    oid = rsp_id;
    for (int s = 0; s < stall; s++) begin
      chk("stall_valid", 32'(rsp_valid), 1);
      chk("stall_product", 32'(rsp_product), 32'(ep));
      chk("stall_id", 32'(rsp_id), 32'(g));
      chk("stall_ready", 32'(req_ready), 0);
      chk("stall_busy", 32'(busy), 1);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_product", 32'(rsp_product), 32'(ep));
    chk("rsp_id", 32'(rsp_id), 32'(g));
    chk("rsp_req_ready", 32'(req_ready), 0);
    tick();
    chk("post_rsp_valid", 32'(rsp_valid), 0);
    chk("post_busy", 32'(busy), 0);
  endtask

  logic [15:0] p_o;
  logic [1:0]  id_o;
  logic [15:0] fair_exp [4] = '{16'h0000, 16'h0033, 16'h0066, 16'h0099};
  logic [7:0]  edge_a   [3] = '{8'h00, 8'h80, 8'h01};
  logic [7:0]  edge_b   [3] = '{8'hAB, 8'h02, 8'hFF};
  logic [15:0] edge_p   [3] = '{16'h0000, 16'h0100, 16'h00FF};

  initial begin
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    for (int i = 0; i < N; i++) begin ta[i] = '0; tbv[i] = '0; end

    // reset values, with requests pending to prove req_ready is held off
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_product", 32'(rsp_product), 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0;
    #1;

    // fairness with all requesters valid
    for (int i = 0; i < N; i++) begin ta[i] = 8'(i * 8'h11); tbv[i] = 8'h03; end
    for (int i = 0; i < N; i++) begin
      run_txn(4'hF, 0, p_o, id_o);
      chk("fair_product", 32'(p_o), 32'(fair_exp[i]));
      chk("fair_id", 32'(id_o), i);
    end

    // single requester 2 with max operands
    do_reset();
    ta[2] = 8'hFF; tbv[2] = 8'hFF;
    run_txn(4'b0100, 0, p_o, id_o);
    chk("max_product", 32'(p_o), 32'hFE01);
    chk("max_id", 32'(id_o), 2);

    // requesters 1 and 3 alternate
    do_reset();
    for (int k = 0; k < 4; k++) begin
      run_txn(4'b1010, 0, p_o, id_o);
      chk("alt_id", 32'(id_o), (k % 2 == 0) ? 1 : 3);
    end

    // stall in RSP while others keep requesting
    for (int i = 0; i < N; i++) begin ta[i] = 8'($urandom); tbv[i] = 8'($urandom); end
    run_txn(4'hF, 5, p_o, id_o);

    // no requests: nothing granted, pointer held
    req_valid = '0;
    #1;
    chk("idle_req_ready", 32'(req_ready), 0);
    tick();
    chk("idle_busy", 32'(busy), 0);

    // edge operands via requester 0 alone
    for (int e = 0; e < 3; e++) begin
      ta[0] = edge_a[e]; tbv[0] = edge_b[e];
      run_txn(4'b0001, 0, p_o, id_o);
      chk("edge_product", 32'(p_o), 32'(edge_p[e]));
    end

    // randomized masks, operands and stalls
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++) begin ta[i] = 8'($urandom); tbv[i] = 8'($urandom); end
      run_txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), p_o, id_o);
    end

    // reset during MUL drops the operation
    req_valid = 4'hF; rsp_ready = 1'b1;
    #1;
    tick();
    chk("mul_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_product", 32'(rsp_product), 0);
    chk("midrst_id", 32'(rsp_id), 0);
    tick();
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    rst_n = 1'b1;
    mptr = 0;
    #1;
    chk("after_rst_rsp_valid", 32'(rsp_valid), 0);
    for (int i = 0; i < N; i++) begin ta[i] = 8'(i + 5); tbv[i] = 8'(i + 7); end
    run_txn(4'hF, 0, p_o, id_o);
    chk("after_rst_id", 32'(id_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
